// File: rtl/spi_target.sv
`timescale 1ns/1ps
// spi_target: SPI mode-0 target with a 16 x 8-bit register file.
//
// The SPI pins are asynchronous to io_clock. Each one passes through a
// 2-flop synchronizer, and the logic acts only on synchronized edges.
// This supports an sclk of up to io_clock/8.
// The first byte of a transaction is a command:
//   bit7    = 1 for read, 0 for write
//   bits3:0 = start address
// Data bytes then stream to or from consecutive addresses, which wrap modulo 16.
//
// Ports:
//   io_clock, io_resetn           system clock, async active-low reset
//   io_spi_sclk/ss/mosi           SPI inputs (async)
//   io_spi_miso, io_spi_misoEn    SPI data out and pad output-enable
//   io_localAddr, io_localRdata   combinational local read port
//   io_wrStrobe/wrAddr/wrData     one-cycle notification per byte written
//   io_interrupt                  only when SPI_TARGET_IRQ_EN is defined:
//                                 one-cycle pulse at the end of a transaction
//                                 that wrote at least one byte
//
// Optional feature macro: SPI_TARGET_IRQ_EN
//
// state | meaning
// IDLE  | waiting for ss falling edge
// CMD   | receiving the command byte
// WRITE | each received byte is written to regs[addr]
// READ  | regs[addr] is shifted out on miso
module spi_target (
  input  logic       io_clock,
  input  logic       io_resetn,
  input  logic       io_spi_sclk,
  input  logic       io_spi_ss,
  input  logic       io_spi_mosi,
  output logic       io_spi_miso,
  output logic       io_spi_misoEn,
  input  logic [3:0] io_localAddr,
  output logic [7:0] io_localRdata,
  output logic       io_wrStrobe,
  output logic [3:0] io_wrAddr,
  output logic [7:0] io_wrData
`ifdef SPI_TARGET_IRQ_EN
  ,output logic      io_interrupt
`endif
);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t     state_q, state_d;
  logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic       ss_s1_q, ss_s2_q, ss_s3_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [3:0] addr_q, addr_d;
  logic       miso_q, miso_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic       wr_strobe_q, wr_strobe_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] rx_byte;
  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
`ifdef SPI_TARGET_IRQ_EN
  logic       wrote_q, wrote_d;
  logic       irq_q, irq_d;
`endif

  // The third stage of sclk and ss is only the previous value, used for edge detection.
  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign ss_fall   = ~ss_s2_q & ss_s3_q;
  assign ss_rise   = ss_s2_q & ~ss_s3_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rx_byte     = {rx_q[6:0], mosi_s2_q};
`ifdef SPI_TARGET_IRQ_EN
    wrote_d     = wrote_q;
    irq_d       = 1'b0;
`endif
    if (state_q == IDLE) begin
      miso_d = 1'b0;
      if (ss_fall) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
        rx_d      = 8'h00;
        tx_d      = 8'h00;
      end
    end else if (ss_rise) begin
      // A partial byte is simply dropped: nothing has been committed for it yet.
      state_d = IDLE;
      miso_d  = 1'b0;
`ifdef SPI_TARGET_IRQ_EN
      irq_d   = wrote_q;
      wrote_d = 1'b0;
`endif
    end else begin
      if (sclk_rise) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == CMD) begin
            if (rx_byte[7]) begin
              state_d = READ;
              tx_d    = regs_q[rx_byte[3:0]];
              addr_d  = rx_byte[3:0] + 4'd1;
            end else begin
              state_d = WRITE;
              addr_d  = rx_byte[3:0];
            end
          end else if (state_q == WRITE) begin
            regs_d[addr_q] = rx_byte;
            wr_strobe_d    = 1'b1;
            wr_addr_d      = addr_q;
            wr_data_d      = rx_byte;
            addr_d         = addr_q + 4'd1;
`ifdef SPI_TARGET_IRQ_EN
            wrote_d        = 1'b1;
`endif
          end else begin
            tx_d   = regs_q[addr_q];
            addr_d = addr_q + 4'd1;
          end
        end
      end
      // Loads happen on rising edges only, so the first falling edge after a
      // load presents the MSB and each later falling edge advances one bit.
      if (sclk_fall && state_q == READ) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge io_clock or negedge io_resetn) begin
    if (!io_resetn) begin
      state_q     <= IDLE;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      ss_s1_q     <= 1'b1;
      ss_s2_q     <= 1'b1;
      ss_s3_q     <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      addr_q      <= 4'd0;
      miso_q      <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= 8'h00;
`ifdef SPI_TARGET_IRQ_EN
      wrote_q     <= 1'b0;
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sclk_s1_q   <= io_spi_sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      ss_s1_q     <= io_spi_ss;
      ss_s2_q     <= ss_s1_q;
      ss_s3_q     <= ss_s2_q;
      mosi_s1_q   <= io_spi_mosi;
      mosi_s2_q   <= mosi_s1_q;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
`ifdef SPI_TARGET_IRQ_EN
      wrote_q     <= wrote_d;
      irq_q       <= irq_d;
`endif
    end
  end

  assign io_spi_miso   = miso_q;
  assign io_spi_misoEn = ~ss_s2_q;
  assign io_localRdata = regs_q[io_localAddr];
  assign io_wrStrobe   = wr_strobe_q;
  assign io_wrAddr     = wr_addr_q;
  assign io_wrData     = wr_data_q;
`ifdef SPI_TARGET_IRQ_EN
  assign io_interrupt  = irq_q;
`endif

endmodule

// File: tb/tb_spi_target.sv
`timescale 1ns/1ps
// Directed bench for spi_target: SPI writes and reads, address wrap-around,
// an aborted partial byte, reset during a read, and the optional interrupt.
module tb_spi_target;

  logic       io_clock = 1'b0;
  logic       io_resetn;
  logic       io_spi_sclk;
  logic       io_spi_ss;
  logic       io_spi_mosi;
  logic       io_spi_miso;
  logic       io_spi_misoEn;
  logic [3:0] io_localAddr;
  logic [7:0] io_localRdata;
  logic       io_wrStrobe;
  logic [3:0] io_wrAddr;
  logic [7:0] io_wrData;
`ifdef SPI_TARGET_IRQ_EN
  logic       io_interrupt;
`endif

  spi_target dut (
    .io_clock      (io_clock),
    .io_resetn     (io_resetn),
    .io_spi_sclk   (io_spi_sclk),
    .io_spi_ss     (io_spi_ss),
    .io_spi_mosi   (io_spi_mosi),
    .io_spi_miso   (io_spi_miso),
    .io_spi_misoEn (io_spi_misoEn),
    .io_localAddr  (io_localAddr),
    .io_localRdata (io_localRdata),
    .io_wrStrobe   (io_wrStrobe),
    .io_wrAddr     (io_wrAddr),
    .io_wrData     (io_wrData)
`ifdef SPI_TARGET_IRQ_EN
    ,.io_interrupt (io_interrupt)
`endif
  );

  always #5 io_clock = ~io_clock;

  int checks = 0;
  int errors = 0;

  // Record every cycle in which the write strobe is high.
  int         strobe_cnt = 0;
  logic [3:0] log_addr [16];
  logic [7:0] log_data [16];
  always @(posedge io_clock) begin
    if (io_wrStrobe === 1'b1) begin
      log_addr[strobe_cnt[3:0]] = io_wrAddr;
      log_data[strobe_cnt[3:0]] = io_wrData;
      strobe_cnt++;
    end
  end

`ifdef SPI_TARGET_IRQ_EN
  int irq_cnt = 0;
  always @(posedge io_clock) if (io_interrupt === 1'b1) irq_cnt++;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sclk half period is 5 clocks, slower than the io_clock/8 limit.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      io_spi_mosi = tx[i];
      #50;
      io_spi_sclk = 1'b1;
      rx[i] = io_spi_miso;
      #50;
      io_spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic ss_low();
    io_spi_ss = 1'b0;
    #100;
  endtask

  task automatic ss_high();
    #100;
    io_spi_ss = 1'b1;
    #100;
  endtask

  task automatic local_rd(input logic [3:0] a, output logic [7:0] d);
    io_localAddr = a;
    #10;
    d = io_localRdata;
  endtask

  initial begin
    logic [7:0] r, r1, r2, d;
    int s0;
`ifdef SPI_TARGET_IRQ_EN
    int i0;
`endif
    io_resetn    = 1'b0;
    io_spi_sclk  = 1'b0;
    io_spi_ss    = 1'b1;
    io_spi_mosi  = 1'b0;
    io_localAddr = 4'd0;
    #23;
    check("rst_miso", io_spi_miso, 1'b0);
    check("rst_misoen", io_spi_misoEn, 1'b0);
    check("rst_strobe", io_wrStrobe, 1'b0);
    check("rst_wraddr", io_wrAddr, 4'd0);
    check("rst_wrdata", io_wrData, 8'h00);
    check("rst_rdata0", io_localRdata, 8'h00);
    #20;
    io_resetn = 1'b1;
    #100;

    // Write 0xA5, 0x5A starting at address 3.
    s0 = strobe_cnt;
`ifdef SPI_TARGET_IRQ_EN
    i0 = irq_cnt;
`endif
    ss_low();
    check("misoen_active", io_spi_misoEn, 1'b1);
    spi_byte(8'h03, r);
    check("cmd_miso_zero", r, 8'h00);
    spi_byte(8'hA5, r);
    spi_byte(8'h5A, r);
    ss_high();
    check("misoen_idle", io_spi_misoEn, 1'b0);
    check("wr_strobe_cnt", strobe_cnt - s0, 2);
    check("wr_log_addr0", log_addr[s0[3:0]], 4'd3);
    check("wr_log_data0", log_data[s0[3:0]], 8'hA5);
    check("wr_log_addr1", log_addr[4'(s0 + 1)], 4'd4);
    check("wr_log_data1", log_data[4'(s0 + 1)], 8'h5A);
    local_rd(4'd3, d);
    check("reg3", d, 8'hA5);
    local_rd(4'd4, d);
    check("reg4", d, 8'h5A);
`ifdef SPI_TARGET_IRQ_EN
    check("irq_after_write", irq_cnt - i0, 1);
`endif

    // Read back from address 3.
    s0 = strobe_cnt;
`ifdef SPI_TARGET_IRQ_EN
    i0 = irq_cnt;
`endif
    ss_low();
    spi_byte(8'h83, r);
    check("rd_cmd_miso_zero", r, 8'h00);
    spi_byte(8'h00, r1);
    spi_byte(8'h00, r2);
    ss_high();
    check("rd_byte0", r1, 8'hA5);
    check("rd_byte1", r2, 8'h5A);
    check("rd_no_strobe", strobe_cnt - s0, 0);
`ifdef SPI_TARGET_IRQ_EN
    check("irq_after_read", irq_cnt - i0, 0);
`endif

    // Write wrap-around from address 15 to 0.
    ss_low();
    spi_byte(8'h0F, r);
    spi_byte(8'h11, r);
    spi_byte(8'h22, r);
    ss_high();
    local_rd(4'd15, d);
    check("reg15_wrap", d, 8'h11);
    local_rd(4'd0, d);
    check("reg0_wrap", d, 8'h22);

    // Read wrap-around; bits 6:4 of the command are ignored.
    ss_low();
    spi_byte(8'hFF, r);
    spi_byte(8'h00, r1);
    spi_byte(8'h00, r2);
    ss_high();
    check("rd_wrap0", r1, 8'h11);
    check("rd_wrap1", r2, 8'h22);

    // Seed regs[2], then abort a partial byte targeting it.
    ss_low();
    spi_byte(8'h02, r);
    spi_byte(8'h55, r);
    ss_high();
    s0 = strobe_cnt;
    ss_low();
    spi_byte(8'h02, r);
    spi_bits(8'hFF, 5, r);
    ss_high();
    local_rd(4'd2, d);
    check("partial_reg2", d, 8'h55);
    check("partial_no_strobe", strobe_cnt - s0, 0);
    s0 = strobe_cnt;
    ss_low();
    spi_byte(8'h05, r);
    spi_byte(8'h77, r);
    ss_high();
    local_rd(4'd5, d);
    check("after_partial_reg5", d, 8'h77);
    check("after_partial_strobe", strobe_cnt - s0, 1);
    check("after_partial_addr", log_addr[s0[3:0]], 4'd5);
    local_rd(4'd2, d);
    check("after_partial_reg2", d, 8'h55);

    // Reset in the middle of a read of regs[3] (0xA5, MSB already on miso).
    ss_low();
    spi_byte(8'h83, r);
    #100;
    check("pre_reset_miso", io_spi_miso, 1'b1);
    spi_bits(8'h00, 3, r);
    io_resetn = 1'b0;
    #10;
    check("midrst_miso", io_spi_miso, 1'b0);
    check("midrst_misoen", io_spi_misoEn, 1'b0);
    check("midrst_strobe", io_wrStrobe, 1'b0);
    check("midrst_wraddr", io_wrAddr, 4'd0);
    check("midrst_wrdata", io_wrData, 8'h00);
    for (int a = 0; a < 16; a++) begin
      io_localAddr = 4'(a);
      #10;
      check($sformatf("midrst_reg%0d", a), io_localRdata, 8'h00);
    end
    io_spi_ss = 1'b1;
    #50;
    io_resetn = 1'b1;
    #100;

    // A normal transaction after the reset.
    s0 = strobe_cnt;
    ss_low();
    spi_byte(8'h01, r);
    spi_byte(8'h3C, r);
    ss_high();
    local_rd(4'd1, d);
    check("post_rst_reg1", d, 8'h3C);
    check("post_rst_strobe", strobe_cnt - s0, 1);
    local_rd(4'd3, d);
    check("post_rst_reg3", d, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
- REQ-001 SHALL have port io_clock, input, 1, sole system clock; SPI inputs are asynchronous to it.
- REQ-002 SHALL have port io_resetn, input, 1, asynchronous active-low reset.
- REQ-003 SHALL have port io_spi_sclk, input, 1, SPI clock from the initiator; mode 0 (CPOL=0, CPHA=0).
- REQ-004 SHALL have port io_spi_ss, input, 1, active-low target select.
- REQ-005 SHALL have port io_spi_mosi, input, 1, initiator-to-target data, MSB first.
- REQ-006 SHALL have port io_spi_miso, output, 1, target-to-initiator data, MSB first.
- REQ-007 SHALL have port io_spi_misoEn, output, 1, pad output-enable, high while the synchronized ss is low.
- REQ-008 SHALL have port io_localAddr, input, 4, local read address.
- REQ-009 SHALL have port io_localRdata, output, 8, combinational read of regs[io_localAddr].
- REQ-010 SHALL have port io_wrStrobe, output, 1, one-cycle pulse per byte written over SPI.
- REQ-011 SHALL have port io_wrAddr, output, 4, address of the byte written, valid with io_wrStrobe.
- REQ-012 SHALL have port io_wrData, output, 8, data of the byte written, valid with io_wrStrobe.

Function
- REQ-013 SHALL pass sclk, ss and mosi through 2-flop synchronizers and act only on synchronized edges; supported sclk is up to io_clock/8.
- REQ-014 SHALL hold a 16 x 8-bit register file.
- REQ-015 SHALL use states IDLE, CMD, WRITE and READ.
- REQ-016 SHALL go IDLE->CMD on synchronized ss falling; bit counter = 0, shift register cleared.
- REQ-017 SHALL shift mosi into the receive shift register on each synchronized sclk rising edge; the 3-bit bit counter wraps 7->0 to mark a byte.
- REQ-018 SHALL decode the byte completed in CMD as: bit7 = 1 read, 0 write; bits3:0 = start address; bits6:4 ignored.
- REQ-019 SHALL, on a write command, enter WRITE; each completed byte writes regs[addr], pulses io_wrStrobe for one cycle and increments addr.
- REQ-020 SHALL, on a read command, enter READ and load regs[addr] into the transmit shift register on the same cycle the command completes, then increment addr.
- REQ-021 SHALL, in READ, load regs[addr] and increment addr on each completed byte.
- REQ-022 SHALL, in READ, drive the transmit MSB on io_spi_miso at the first synchronized sclk falling edge after each load, then shift it on each subsequent falling edge.
- REQ-023 SHALL hold io_spi_miso at 0 in IDLE and CMD.
- REQ-024 SHALL wrap the address 15->0 modulo 16.
- REQ-025 SHALL return to IDLE from any state on synchronized ss rising; a partial byte is discarded with no write, no strobe and no address change.
- REQ-026 SHALL give the SPI write priority when a local read addresses the register being written in the same cycle; io_localRdata shows the old value that cycle and the new value the next.

Reset
- REQ-027 SHALL, while io_resetn is low, asynchronously force: state IDLE; all regs 0x00; shift registers, counter and addr 0; io_spi_miso 0; io_spi_misoEn 0; io_wrStrobe 0; io_wrAddr 0; io_wrData 0x00.
- REQ-028 SHALL set synchronizer flops to idle levels on reset (sclk 0, ss 1, mosi 0); a reset mid-transaction aborts it, and the target waits for a fresh ss falling edge.

Configuration
- REQ-029 SHALL, with SPI_TARGET_IRQ_EN defined, add output io_interrupt (1 bit, reset 0) that pulses for one cycle on ss rising after any transaction that wrote at least one byte.
- REQ-030 SHALL, without SPI_TARGET_IRQ_EN, have no io_interrupt port and no related logic.

Verification
- REQ-031 SHALL cover: write 0x03,0xA5,0x5A -> regs[3]=0xA5, regs[4]=0x5A; two io_wrStrobe pulses with addr 3/4.
- REQ-032 SHALL cover: after REQ-031, send 0x83 plus two dummy bytes -> miso returns 0xA5, 0x5A.
- REQ-033 SHALL cover: write 0x0F,0x11,0x22 -> regs[15]=0x11, regs[0]=0x22 (wrap-around).
- REQ-034 SHALL cover: write 0x02, then 5 bits, then ss high -> regs[2] unchanged, no strobe, next transaction decodes normally.
- REQ-035 SHALL cover: assert io_resetn low during a READ byte -> outputs at reset values immediately, regs all 0x00; io_localRdata=0x00 for every address.
- REQ-036 SHALL cover: with SPI_TARGET_IRQ_EN, write transaction -> one io_interrupt pulse after ss rises; read-only transaction -> none.
